// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT output-side frame receiver.
//   FFT_LEN   : bins per frame
//   FFT_IDX_W : bin index width
//   FFT_DW    : signed sample width of real/imag parts
//   mag_t     : unsigned |re|+|im| magnitude (FFT_DW+1 bits)
//   state_e   : receiver FSM states
package fft_pkg;

  localparam int FFT_LEN   = 1024;
  localparam int FFT_IDX_W = $clog2(FFT_LEN);
  localparam int FFT_DW    = 16;

  typedef logic [FFT_DW:0] mag_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fft_mag_abs.sv
// Combinational |re| + |im| for one complex bin.
//   re_i, im_i : signed DW-bit real/imaginary parts
//   mag_o      : unsigned DW+1-bit magnitude, saturated at all-ones
// The absolute values are formed in DW+1 bits so that -2^(DW-1) maps to
// +2^(DW-1) without overflow.
module fft_mag_abs
  import fft_pkg::*;
#(
  parameter int DW = FFT_DW
) (
  input  logic signed [DW-1:0] re_i,
  input  logic signed [DW-1:0] im_i,
  output logic        [DW:0]   mag_o
);

  logic [DW:0]   abs_re;
  logic [DW:0]   abs_im;
  logic [DW+1:0] sum;

  always_comb begin
    // Two's-complement negate of the sign-extended value: ~{1,x} + 1 = {0,~x} + 1.
    abs_re = re_i[DW-1] ? ({1'b0, ~re_i} + (DW+1)'(1)) : {1'b0, re_i};
    abs_im = im_i[DW-1] ? ({1'b0, ~im_i} + (DW+1)'(1)) : {1'b0, im_i};
    sum    = {1'b0, abs_re} + {1'b0, abs_im};
    mag_o  = sum[DW+1] ? '1 : sum[DW:0];
  end

endmodule

// File: rtl/fft_frame_receiver.sv
// Avalon-ST sink for the FFT output. Receives one sop/eop-delimited frame of
// N complex bins, writes |re|+|im| of each bin to the spectrum RAM one cycle
// after acceptance, and reports the peak bin of the lower half-spectrum
// (bins 1..N/2-1) to the note-detection logic.
//   i_clk, i_reset_n            : clock, asynchronous active-low reset
//   i_sink_valid/sop/eop/real/imag, o_sink_ready : Avalon-ST sink
//   i_frame_ack                 : consumer took the result, re-arm from DONE
//   o_bin_we/addr/mag           : spectrum RAM write port
//   o_frame_done / o_frame_err  : 1-cycle status pulses
//   o_peak_bin / o_peak_mag     : peak of the last good frame
module fft_frame_receiver
  import fft_pkg::*;
#(
  parameter int N     = FFT_LEN,
  parameter int DW    = FFT_DW,
  parameter int IDX_W = FFT_IDX_W
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_sink_valid,
  input  logic             i_sink_sop,
  input  logic             i_sink_eop,
  input  logic [DW-1:0]    i_sink_real,
  input  logic [DW-1:0]    i_sink_imag,
  output logic             o_sink_ready,
  input  logic             i_frame_ack,
  output logic             o_bin_we,
  output logic [IDX_W-1:0] o_bin_addr,
  output logic [DW:0]      o_bin_mag,
  output logic             o_frame_done,
  output logic             o_frame_err,
  output logic [IDX_W-1:0] o_peak_bin,
  output logic [DW:0]      o_peak_mag
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] HALF_IDX = IDX_W'(N / 2);

  state_e           state_q,    state_d;
  logic [IDX_W-1:0] idx_q,      idx_d;
  logic [IDX_W-1:0] run_bin_q,  run_bin_d;
  logic [DW:0]      run_mag_q,  run_mag_d;
  logic             bin_we_q,   bin_we_d;
  logic [IDX_W-1:0] bin_addr_q, bin_addr_d;
  logic [DW:0]      bin_mag_q,  bin_mag_d;
  logic             done_q,     done_d;
  logic             err_q,      err_d;
  logic [IDX_W-1:0] peak_bin_q, peak_bin_d;
  logic [DW:0]      peak_mag_q, peak_mag_d;

  logic             accept;
  logic [DW:0]      beat_mag;
  logic             in_range;
  logic             peak_upd;
  logic [IDX_W-1:0] cand_bin;
  logic [DW:0]      cand_mag;

  fft_mag_abs #(
    .DW (DW)
  ) u_mag_abs (
    .re_i  (i_sink_real),
    .im_i  (i_sink_imag),
    .mag_o (beat_mag)
  );

  assign o_sink_ready = (state_q != DONE);
  assign accept       = i_sink_valid && o_sink_ready;

  // Candidate running peak after considering the current non-sop beat.
  always_comb begin
    in_range = (idx_q != '0) && (idx_q < HALF_IDX);
    peak_upd = in_range && (beat_mag > run_mag_q);
    cand_bin = peak_upd ? idx_q    : run_bin_q;
    cand_mag = peak_upd ? beat_mag : run_mag_q;
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    run_bin_d  = run_bin_q;
    run_mag_d  = run_mag_q;
    bin_we_d   = 1'b0;
    bin_addr_d = bin_addr_q;
    bin_mag_d  = bin_mag_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    peak_bin_d = peak_bin_q;
    peak_mag_d = peak_mag_q;

    unique case (state_q)
      IDLE: begin
        if (accept && i_sink_sop) begin
          bin_we_d   = 1'b1;
          bin_addr_d = '0;
          bin_mag_d  = beat_mag;
          idx_d      = IDX_W'(1);
          run_bin_d  = '0;
          run_mag_d  = '0;
          state_d    = RECV;
        end
      end

      RECV: begin
        if (accept) begin
          bin_we_d  = 1'b1;
          bin_mag_d = beat_mag;
          if (i_sink_sop) begin
            // Restart: flag the broken frame, but keep this beat as bin 0.
            err_d      = 1'b1;
            bin_addr_d = '0;
            idx_d      = IDX_W'(1);
            run_bin_d  = '0;
            run_mag_d  = '0;
          end else begin
            bin_addr_d = idx_q;
            run_bin_d  = cand_bin;
            run_mag_d  = cand_mag;
            if (idx_q == LAST_IDX) begin
              idx_d = '0;
              if (i_sink_eop) begin
                done_d     = 1'b1;
                peak_bin_d = cand_bin;
                peak_mag_d = cand_mag;
                state_d    = DONE;
              end else begin
                err_d   = 1'b1;
                state_d = IDLE;
              end
            end else if (i_sink_eop) begin
              err_d   = 1'b1;
              idx_d   = '0;
              state_d = IDLE;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
      end

      DONE: begin
        if (i_frame_ack) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      run_bin_q  <= '0;
      run_mag_q  <= '0;
      bin_we_q   <= 1'b0;
      bin_addr_q <= '0;
      bin_mag_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      peak_bin_q <= '0;
      peak_mag_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      run_bin_q  <= run_bin_d;
      run_mag_q  <= run_mag_d;
      bin_we_q   <= bin_we_d;
      bin_addr_q <= bin_addr_d;
      bin_mag_q  <= bin_mag_d;
      done_q     <= done_d;
      err_q      <= err_d;
      peak_bin_q <= peak_bin_d;
      peak_mag_q <= peak_mag_d;
    end
  end

  assign o_bin_we     = bin_we_q;
  assign o_bin_addr   = bin_addr_q;
  assign o_bin_mag    = bin_mag_q;
  assign o_frame_done = done_q;
  assign o_frame_err  = err_q;
  assign o_peak_bin   = peak_bin_q;
  assign o_peak_mag   = peak_mag_q;

endmodule

// File: tb/tb_fft_frame_receiver.sv
module tb_fft_frame_receiver;

  localparam int N     = 1024;
  localparam int DW    = 16;
  localparam int IDX_W = 10;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             valid, sop, eop, ack;
  logic [DW-1:0]    re, im;
  logic             ready, bin_we, frame_done, frame_err;
  logic [IDX_W-1:0] bin_addr, peak_bin;
  logic [DW:0]      bin_mag, peak_mag;

  int checks = 0;
  int errors = 0;

  int wr_cnt = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0;
  int wr0, done0, err0, both0;
  logic [DW:0]   ram   [N];
  logic [DW-1:0] stim_re [N];
  logic [DW-1:0] stim_im [N];

  always #5 clk = ~clk;

  fft_frame_receiver #(
    .N     (N),
    .DW    (DW),
    .IDX_W (IDX_W)
  ) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_sink_valid (valid),
    .i_sink_sop   (sop),
    .i_sink_eop   (eop),
    .i_sink_real  (re),
    .i_sink_imag  (im),
    .o_sink_ready (ready),
    .i_frame_ack  (ack),
    .o_bin_we     (bin_we),
    .o_bin_addr   (bin_addr),
    .o_bin_mag    (bin_mag),
    .o_frame_done (frame_done),
    .o_frame_err  (frame_err),
    .o_peak_bin   (peak_bin),
    .o_peak_mag   (peak_mag)
  );

  // Observe the write port and status pulses mid-cycle.
  always @(negedge clk) begin
    if (bin_we === 1'b1) begin
      wr_cnt++;
      ram[bin_addr] = bin_mag;
    end
    if (frame_done === 1'b1) done_cnt++;
    if (frame_err === 1'b1) err_cnt++;
    if (frame_done === 1'b1 && frame_err === 1'b1) both_cnt++;
  end

  task automatic snap();
    wr0 = wr_cnt; done0 = done_cnt; err0 = err_cnt; both0 = both_cnt;
  endtask

  task automatic beat(input logic s, input logic e, input logic [DW-1:0] r, input logic [DW-1:0] i);
    @(negedge clk);
    valid = 1'b1; sop = s; eop = e; re = r; im = i;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid = 1'b0; sop = 1'b0; eop = 1'b0; re = '0; im = '0;
    end
  endtask

  task automatic clear_stim();
    for (int k = 0; k < N; k++) begin
      stim_re[k] = '0;
      stim_im[k] = '0;
    end
  endtask

  task automatic send_frame(input int len, input bit with_eop);
    for (int k = 0; k < len; k++)
      beat(k == 0, with_eop && (k == len - 1), stim_re[k], stim_im[k]);
    idle(2);
  endtask

  task automatic do_ack();
    @(negedge clk); ack = 1'b1;
    @(negedge clk); ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid = 1'b0; sop = 1'b0; eop = 1'b0; ack = 1'b0; re = '0; im = '0;
    #12;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0d want 1", ready); end
    checks++; if (bin_we !== 1'b0 || bin_addr !== '0 || bin_mag !== '0) begin
      errors++; $display("FAIL reset_bin got we=%0d addr=%0d mag=%0d want 0/0/0", bin_we, bin_addr, bin_mag); end
    checks++; if (frame_done !== 1'b0 || frame_err !== 1'b0) begin
      errors++; $display("FAIL reset_pulses got done=%0d err=%0d want 0/0", frame_done, frame_err); end
    checks++; if (peak_bin !== '0 || peak_mag !== '0) begin
      errors++; $display("FAIL reset_peak got %0d/%0d want 0/0", peak_bin, peak_mag); end
    @(negedge clk); rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_ramp();
    int bad;
    snap();
    for (int k = 0; k < N; k++) begin
      beat(k == 0, k == N - 1, DW'(k), '0);
      if (k == 2) begin
        checks++; if (bin_we !== 1'b1 || bin_addr !== 10'd1 || bin_mag !== 17'd1) begin
          errors++; $display("FAIL ramp_latency got we=%0d addr=%0d mag=%0d want 1/1/1", bin_we, bin_addr, bin_mag); end
      end
    end
    idle(2);
    bad = 0;
    for (int k = 0; k < N; k++) if (ram[k] !== 17'(k)) bad++;
    checks++; if (wr_cnt - wr0 !== N) begin errors++; $display("FAIL ramp_writes got %0d want %0d", wr_cnt - wr0, N); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL ramp_ram got %0d bad bins want 0", bad); end
    checks++; if (done_cnt - done0 !== 1 || err_cnt - err0 !== 0) begin
      errors++; $display("FAIL ramp_pulses got done=%0d err=%0d want 1/0", done_cnt - done0, err_cnt - err0); end
    checks++; if (peak_bin !== 10'd511 || peak_mag !== 17'd511) begin
      errors++; $display("FAIL ramp_peak got %0d/%0d want 511/511", peak_bin, peak_mag); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL ramp_ready_done got %0d want 0", ready); end
    do_ack();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL ramp_ready_ack got %0d want 1", ready); end
  endtask

  task automatic test_tie();
    clear_stim();
    stim_re[100] = 16'd500;
    stim_im[300] = 16'hFE0C;  // -500
    stim_re[700] = 16'd900;
    snap();
    send_frame(N, 1'b1);
    checks++; if (peak_bin !== 10'd100 || peak_mag !== 17'd500) begin
      errors++; $display("FAIL tie_peak got %0d/%0d want 100/500", peak_bin, peak_mag); end
    checks++; if (ram[300] !== 17'd500 || ram[700] !== 17'd900) begin
      errors++; $display("FAIL tie_ram got %0d/%0d want 500/900", ram[300], ram[700]); end
    checks++; if (done_cnt - done0 !== 1) begin errors++; $display("FAIL tie_done got %0d want 1", done_cnt - done0); end
    do_ack();
  endtask

  task automatic test_early_eop();
    clear_stim();
    stim_re[50] = 16'd1000;
    snap();
    send_frame(501, 1'b1);
    checks++; if (err_cnt - err0 !== 1 || done_cnt - done0 !== 0) begin
      errors++; $display("FAIL eop_pulses got err=%0d done=%0d want 1/0", err_cnt - err0, done_cnt - done0); end
    checks++; if (wr_cnt - wr0 !== 501) begin errors++; $display("FAIL eop_writes got %0d want 501", wr_cnt - wr0); end
    checks++; if (peak_bin !== 10'd100 || peak_mag !== 17'd500) begin
      errors++; $display("FAIL eop_peak_kept got %0d/%0d want 100/500", peak_bin, peak_mag); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL eop_ready got %0d want 1", ready); end
    clear_stim();
    stim_re[7] = 16'd3;
    snap();
    send_frame(N, 1'b1);
    checks++; if (done_cnt - done0 !== 1 || peak_bin !== 10'd7 || peak_mag !== 17'd3) begin
      errors++; $display("FAIL eop_recover got done=%0d peak=%0d/%0d want 1 7/3", done_cnt - done0, peak_bin, peak_mag); end
    do_ack();
  endtask

  task automatic test_no_eop();
    clear_stim();
    stim_re[9] = 16'd4000;
    snap();
    send_frame(N, 1'b0);
    checks++; if (err_cnt - err0 !== 1 || done_cnt - done0 !== 0) begin
      errors++; $display("FAIL noeop_pulses got err=%0d done=%0d want 1/0", err_cnt - err0, done_cnt - done0); end
    checks++; if (peak_bin !== 10'd7 || peak_mag !== 17'd3) begin
      errors++; $display("FAIL noeop_peak_kept got %0d/%0d want 7/3", peak_bin, peak_mag); end
    snap();
    for (int k = 0; k < 3; k++) beat(1'b0, 1'b0, 16'd5, '0);
    idle(2);
    checks++; if (wr_cnt - wr0 !== 0) begin errors++; $display("FAIL noeop_wrap got %0d writes want 0", wr_cnt - wr0); end
  endtask

  task automatic test_restart();
    snap();
    for (int k = 0; k < 200; k++) beat(k == 0, 1'b0, (k == 10) ? 16'd2000 : 16'd0, '0);
    for (int j = 0; j < N; j++) begin
      beat(j == 0, j == N - 1, (j == 20) ? 16'd30 : 16'd0, '0);
      if (j == 1) begin
        checks++; if (bin_we !== 1'b1 || bin_addr !== '0 || frame_err !== 1'b1 || frame_done !== 1'b0) begin
          errors++; $display("FAIL restart_beat got we=%0d addr=%0d err=%0d done=%0d want 1/0/1/0",
                             bin_we, bin_addr, frame_err, frame_done); end
      end
    end
    idle(2);
    checks++; if (err_cnt - err0 !== 1 || done_cnt - done0 !== 1 || both_cnt - both0 !== 0) begin
      errors++; $display("FAIL restart_pulses got err=%0d done=%0d both=%0d want 1/1/0",
                         err_cnt - err0, done_cnt - done0, both_cnt - both0); end
    checks++; if (peak_bin !== 10'd20 || peak_mag !== 17'd30) begin
      errors++; $display("FAIL restart_peak got %0d/%0d want 20/30", peak_bin, peak_mag); end
    checks++; if (wr_cnt - wr0 !== 200 + N) begin
      errors++; $display("FAIL restart_writes got %0d want %0d", wr_cnt - wr0, 200 + N); end
    do_ack();
  endtask

  task automatic test_neg_full();
    clear_stim();
    stim_re[0] = 16'h8000; stim_im[0] = 16'h8000;
    stim_re[5] = 16'h8000; stim_im[5] = 16'h8000;
    send_frame(N, 1'b1);
    checks++; if (ram[0] !== 17'd65536) begin errors++; $display("FAIL neg_mag got %0d want 65536", ram[0]); end
    checks++; if (peak_bin !== 10'd5 || peak_mag !== 17'd65536) begin
      errors++; $display("FAIL neg_peak got %0d/%0d want 5/65536", peak_bin, peak_mag); end
    snap();
    for (int k = 0; k < 5; k++) beat(1'b1, 1'b0, 16'd9, '0);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL done_ready got %0d want 0", ready); end
    idle(2);
    checks++; if (wr_cnt - wr0 !== 0) begin errors++; $display("FAIL done_block got %0d writes want 0", wr_cnt - wr0); end
    do_ack();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL neg_ack_ready got %0d want 1", ready); end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 400; k++) beat(k == 0, 1'b0, (k == 3) ? 16'd77 : 16'd0, '0);
    @(negedge clk);
    valid = 1'b0; sop = 1'b0; rst_n = 1'b0;
    #1;
    snap();
    checks++; if (ready !== 1'b1 || bin_we !== 1'b0 || bin_addr !== '0 || bin_mag !== '0) begin
      errors++; $display("FAIL rstmid_out got ready=%0d we=%0d addr=%0d mag=%0d want 1/0/0/0",
                         ready, bin_we, bin_addr, bin_mag); end
    checks++; if (peak_bin !== '0 || peak_mag !== '0 || frame_done !== 1'b0 || frame_err !== 1'b0) begin
      errors++; $display("FAIL rstmid_peak got %0d/%0d done=%0d err=%0d want 0/0/0/0",
                         peak_bin, peak_mag, frame_done, frame_err); end
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 10; k++) beat(1'b0, 1'b0, 16'd11, '0);
    idle(2);
    checks++; if (wr_cnt - wr0 !== 0 || done_cnt - done0 !== 0 || err_cnt - err0 !== 0) begin
      errors++; $display("FAIL rstmid_idle got wr=%0d done=%0d err=%0d want 0/0/0",
                         wr_cnt - wr0, done_cnt - done0, err_cnt - err0); end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_tie();
    test_early_eop();
    test_no_eop();
    test_restart();
    test_neg_full();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
